// File: rtl/die_roll_decoder_if.sv
// Die-select link between the button encoder (master) and the roll decoder (slave).
// Carries the die code, the raw roll button, and the roll/decode results back out.
interface die_roll_decoder_if;
   logic [3:0] dieSelect;
   logic       rollBtn;
   logic [4:0] rollValue;
   logic       rollDone;
   logic       busy;
   logic [4:0] dieSides;
   logic       selError;

   modport master (
      output dieSelect, rollBtn,
      input  rollValue, rollDone, busy, dieSides, selError
   );

   modport slave (
      input  dieSelect, rollBtn,
      output rollValue, rollDone, busy, dieSides, selError
   );
endinterface

// File: rtl/die_roll_decoder.sv
// Decodes the die-select code and runs the spin/latch roll sequence.
// A wrapping spin counter is sampled when the synchronized button is released.
module die_roll_decoder #(
   parameter int MIN_SPIN = 8,
   parameter int CNT_W    = 8
) (
   input logic               clk,
   input logic               reset,
   die_roll_decoder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SPIN = 2'd1,
      SHOW = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_SPIN);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           r_state;
   state_t           w_next;
   logic             r_sync1;
   logic             r_btnSync;
   logic [4:0]       r_n;
   logic [4:0]       r_spin;
   logic [4:0]       r_testCount;
   logic [4:0]       r_rollValue;
   logic             r_testMode;
   logic [CNT_W-1:0] r_cycleCnt;

   logic [4:0]       w_sides;
   logic             w_selErr;
   logic             w_isTest;
   logic             w_start;
   logic             w_latch;

   // Code decode; 0110 and 1xxx are invalid.
   always_comb begin
      w_sides  = 5'd0;
      w_selErr = 1'b0;
      w_isTest = 1'b0;
      case (bus.dieSelect)
         4'b0000: w_sides = 5'd4;
         4'b0001: w_sides = 5'd6;
         4'b0010: w_sides = 5'd8;
         4'b0011: w_sides = 5'd10;
         4'b0100: w_sides = 5'd12;
         4'b0101: w_sides = 5'd20;
         4'b0111: begin
            w_sides  = 5'd20;
            w_isTest = 1'b1;
         end
         default: w_selErr = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1   <= 1'b0;
         r_btnSync <= 1'b0;
      end else begin
         r_sync1   <= bus.rollBtn;
         r_btnSync <= r_sync1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      w_latch = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_btnSync && !w_selErr) begin
               w_start = 1'b1;
               w_next  = SPIN;
            end
         end
         SPIN: begin
            if (!r_btnSync && (r_cycleCnt >= MIN_C)) begin
               w_latch = 1'b1;
               w_next  = SHOW;
            end
         end
         SHOW:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // N and testMode are captured at roll start so later code changes cannot disturb the roll.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_n         <= 5'd0;
         r_testMode  <= 1'b0;
         r_spin      <= 5'd0;
         r_cycleCnt  <= '0;
         r_testCount <= 5'd1;
         r_rollValue <= 5'd0;
      end else begin
         if (w_start) begin
            r_n        <= w_sides;
            r_testMode <= w_isTest;
            r_spin     <= 5'd1;
            r_cycleCnt <= CNT_W'(1);
         end else if (r_state == SPIN) begin
            r_spin     <= (r_spin == r_n) ? 5'd1 : r_spin + 5'd1;
            r_cycleCnt <= (r_cycleCnt == CNT_MAX) ? r_cycleCnt : r_cycleCnt + CNT_W'(1);
         end
         // Latch uses the pre-increment spin value of the exit cycle.
         if (w_latch)
            r_rollValue <= r_testMode ? r_testCount : r_spin;
         if ((r_state == SHOW) && r_testMode)
            r_testCount <= (r_testCount == 5'd20) ? 5'd1 : r_testCount + 5'd1;
      end
   end

   assign bus.rollValue = r_rollValue;
   assign bus.rollDone  = (r_state == SHOW);
   assign bus.busy      = (r_state != IDLE);
   assign bus.dieSides  = w_sides;
   assign bus.selError  = w_selErr;

endmodule

// File: tb/tb_die_roll_decoder.sv
// Directed bench for die_roll_decoder: decode table, roll timing, test mode,
// invalid codes, mid-roll code change and mid-roll reset.
module tb_die_roll_decoder;
   logic clk;
   logic reset;
   int   n_run;
   int   n_fail;

   die_roll_decoder_if bus ();

   die_roll_decoder #(.MIN_SPIN(8), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      n_run++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Press rollBtn for `hold` sampled edges and watch up to max_c cycles.
   // Optional mid-roll die code switch (sw_at>=0) and reset pulse (rst_at>=0).
   task automatic roll(input int hold, input int max_c, input int sw_at,
                       input logic [3:0] sw_code, input int rst_at,
                       output int val, output int bc, output int dc);
      val = 0; bc = 0; dc = 0;
      bus.rollBtn = 1'b1;
      for (int c = 0; c < max_c; c++) begin
         @(posedge clk); #1;
         if (c + 1 >= hold) bus.rollBtn = 1'b0;
         if (c == sw_at) bus.dieSelect = sw_code;
         if (c == rst_at) begin reset = 1'b1; #1; end
         if (c == rst_at + 2) reset = 1'b0;
         if (bus.busy) bc++;
         if (bus.rollDone) begin dc++; val = int'(bus.rollValue); end
         if (rst_at < 0 && dc > 0 && !bus.busy) break;
      end
   endtask

   int v, bc, dc, exp_s, k, exp_v;

   initial begin
      n_run = 0; n_fail = 0;
      reset = 1'b1;
      bus.dieSelect = 4'b0000;
      bus.rollBtn   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rollValue", int'(bus.rollValue), 0);
      chk("rst_rollDone", int'(bus.rollDone), 0);
      chk("rst_busy", int'(bus.busy), 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Decode table over all 16 codes
      for (int i = 0; i < 16; i++) begin
         bus.dieSelect = 4'(i);
         #1;
         case (i)
            0: exp_s = 4;  1: exp_s = 6;  2: exp_s = 8;  3: exp_s = 10;
            4: exp_s = 12; 5: exp_s = 20; 7: exp_s = 20;
            default: exp_s = 0;
         endcase
         chk($sformatf("sides_%0d", i), int'(bus.dieSides), exp_s);
         chk($sformatf("selerr_%0d", i), int'(bus.selError), (exp_s == 0) ? 1 : 0);
      end

      // D4 single-cycle press: spin 1,2,3,4,1,2,3,4 -> 4
      bus.dieSelect = 4'b0000;
      roll(1, 60, -1, 4'b0000, -1, v, bc, dc);
      chk("d4_value", v, 4);
      chk("d4_busy", bc, 9);
      chk("d4_done", dc, 1);
      chk("d4_hold", int'(bus.rollValue), 4);

      bus.dieSelect = 4'b0001;
      roll(1, 60, -1, 4'b0000, -1, v, bc, dc);
      chk("d6_value", v, 2);

      bus.dieSelect = 4'b0101;
      roll(1, 60, -1, 4'b0000, -1, v, bc, dc);
      chk("d20_value", v, 8);

      // Long press: model spin from the measured SPIN length
      roll(30, 100, -1, 4'b0000, -1, v, bc, dc);
      k = bc - 1;
      exp_v = ((k - 1) % 20) + 1;
      chk("d20_long_spin_len", k, 30);
      chk("d20_long_value", v, exp_v);
      chk("d20_long_range", int'(v >= 1 && v <= 20), 1);

      // TEST mode: sequential results with wrap after 20
      bus.dieSelect = 4'b0111;
      for (int p = 1; p <= 21; p++) begin
         roll(1, 60, -1, 4'b0000, -1, v, bc, dc);
         if (p <= 3 || p >= 20)
            chk($sformatf("test_press_%0d", p), v, (p == 21) ? 1 : p);
      end

      // Invalid codes: no roll, value untouched
      bus.dieSelect = 4'b1111;
      roll(1, 15, -1, 4'b0000, -1, v, bc, dc);
      chk("inv1111_selerr", int'(bus.selError), 1);
      chk("inv1111_sides", int'(bus.dieSides), 0);
      chk("inv1111_busy", bc, 0);
      chk("inv1111_done", dc, 0);
      chk("inv1111_value", int'(bus.rollValue), 1);
      bus.dieSelect = 4'b0110;
      roll(1, 15, -1, 4'b0000, -1, v, bc, dc);
      chk("inv0110_selerr", int'(bus.selError), 1);
      chk("inv0110_busy", bc, 0);
      chk("inv0110_done", dc, 0);
      chk("inv0110_value", int'(bus.rollValue), 1);

      // D4 roll with switch to D20 mid-SPIN
      bus.dieSelect = 4'b0000;
      roll(1, 60, 4, 4'b0101, -1, v, bc, dc);
      chk("sw_value", v, 4);
      chk("sw_range", int'(v >= 1 && v <= 4), 1);
      chk("sw_sides_now", int'(bus.dieSides), 20);

      // Reset at SPIN cycle 3 (SPIN entered at the third edge)
      bus.dieSelect = 4'b0101;
      roll(1, 20, -1, 4'b0000, 4, v, bc, dc);
      chk("rst_mid_done", dc, 0);
      chk("rst_mid_value", int'(bus.rollValue), 0);
      chk("rst_mid_busy", int'(bus.busy), 0);

      bus.dieSelect = 4'b0111;
      roll(1, 60, -1, 4'b0000, -1, v, bc, dc);
      chk("post_rst_test", v, 1);
      chk("post_rst_done", dc, 1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
